regfile_access_ctrl: RTL

- Initiator side of the register-file port interface: accepts READ, WRITE, COPY and CLEAR commands on a valid/ready command channel.
- Sequences the register file's write enable, read/write addresses and write data over multiple cycles.
- Returns one response per command on a valid/ready response channel.
- Sits between the debug/host command path and the 32x32 register file.

---
 rtl/regfile_access_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: sequences READ/WRITE/COPY/CLEAR commands onto a
// single-write, dual-read register file port and returns one response per command.
// Optional build macro: RFC_READBACK_EN adds a verify read after every WRITE/COPY write
// and reports a mismatch on o_rsp_err (tied to 0 when the macro is undefined).
module regfile_access_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // Command channel
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_addr_a,
  input  logic [ADDR_W-1:0] i_cmd_addr_b,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  // Response channel
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data_a,
  output logic [DATA_W-1:0] o_rsp_data_b,
  output logic              o_rsp_err,
  // Register file port
  output logic              o_rf_write,
  output logic [ADDR_W-1:0] o_rf_rdaddr1,
  output logic [ADDR_W-1:0] o_rf_rdaddr2,
  output logic [ADDR_W-1:0] o_rf_wraddr,
  output logic [DATA_W-1:0] o_rf_wrdata,
  input  logic [DATA_W-1:0] i_rf_rddata1,
  input  logic [DATA_W-1:0] i_rf_rddata2
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StClr,
    StVfy,
    StResp
  } state_e;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpCopy  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  state_e            r_state, w_state_d;
  logic [1:0]        r_op, w_op_d;
  logic [ADDR_W-1:0] r_dst, w_dst_d;      // COPY destination, used after the read cycle
  logic [ADDR_W-1:0] r_cnt, w_cnt_d;      // CLEAR index currently being written
  logic              r_rf_write, w_rf_write_d;
  logic [ADDR_W-1:0] r_rf_rdaddr1, w_rf_rdaddr1_d;
  logic [ADDR_W-1:0] r_rf_rdaddr2, w_rf_rdaddr2_d;
  logic [ADDR_W-1:0] r_rf_wraddr, w_rf_wraddr_d;
  logic [DATA_W-1:0] r_rf_wrdata, w_rf_wrdata_d;
  logic              r_rsp_valid, w_rsp_valid_d;
  logic [DATA_W-1:0] r_rsp_data_a, w_rsp_data_a_d;
  logic [DATA_W-1:0] r_rsp_data_b, w_rsp_data_b_d;
`ifdef RFC_READBACK_EN
  logic              r_rsp_err, w_rsp_err_d;
`endif

  // Next-state and next-output logic; rf_write defaults low so it only pulses where driven.
  always_comb begin
    w_state_d      = r_state;
    w_op_d         = r_op;
    w_dst_d        = r_dst;
    w_cnt_d        = r_cnt;
    w_rf_write_d   = 1'b0;
    w_rf_rdaddr1_d = r_rf_rdaddr1;
    w_rf_rdaddr2_d = r_rf_rdaddr2;
    w_rf_wraddr_d  = r_rf_wraddr;
    w_rf_wrdata_d  = r_rf_wrdata;
    w_rsp_valid_d  = r_rsp_valid;
    w_rsp_data_a_d = r_rsp_data_a;
    w_rsp_data_b_d = r_rsp_data_b;
`ifdef RFC_READBACK_EN
    w_rsp_err_d    = r_rsp_err;
`endif

    case (r_state)
      StIdle: begin
        if (i_cmd_valid) begin
          w_op_d         = i_cmd_op;
          w_dst_d        = i_cmd_addr_b;
          w_rsp_data_a_d = '0;
          w_rsp_data_b_d = '0;
`ifdef RFC_READBACK_EN
          w_rsp_err_d    = 1'b0;
`endif
          case (i_cmd_op)
            OpRead: begin
              w_state_d      = StRd;
              w_rf_rdaddr1_d = i_cmd_addr_a;
              w_rf_rdaddr2_d = i_cmd_addr_b;
            end
            OpWrite: begin
              w_state_d     = StWr;
              w_rf_write_d  = 1'b1;
              w_rf_wraddr_d = i_cmd_addr_a;
              w_rf_wrdata_d = i_cmd_wdata;
            end
            OpCopy: begin
              w_state_d      = StRd;
              w_rf_rdaddr1_d = i_cmd_addr_a;
            end
            OpClear: begin
              w_state_d     = StClr;
              w_cnt_d       = '0;
              w_rf_write_d  = 1'b1;
              w_rf_wraddr_d = '0;
              w_rf_wrdata_d = '0;
            end
          endcase
        end
      end

      // Read data sampled at the end of this cycle; write is low so the ports are valid.
      StRd: begin
        if (r_op == OpCopy) begin
          w_state_d      = StWr;
          w_rsp_data_a_d = i_rf_rddata1;
          w_rf_write_d   = 1'b1;
          w_rf_wraddr_d  = r_dst;
          w_rf_wrdata_d  = i_rf_rddata1;
        end else begin
          w_state_d      = StResp;
          w_rsp_data_a_d = i_rf_rddata1;
          w_rsp_data_b_d = i_rf_rddata2;
          w_rsp_valid_d  = 1'b1;
        end
      end

      StWr: begin
`ifdef RFC_READBACK_EN
        w_state_d      = StVfy;
        w_rf_rdaddr1_d = r_rf_wraddr;
`else
        w_state_d      = StResp;
        w_rsp_valid_d  = 1'b1;
`endif
      end

      StVfy: begin
`ifdef RFC_READBACK_EN
        w_state_d     = StResp;
        w_rsp_err_d   = (i_rf_rddata1 != r_rf_wrdata);
        w_rsp_valid_d = 1'b1;
`else
        w_state_d     = StIdle;
`endif
      end

      StClr: begin
        if (r_cnt == LastIdx) begin
          w_state_d     = StResp;
          w_rsp_valid_d = 1'b1;
        end else begin
          w_cnt_d       = r_cnt + ADDR_W'(1);
          w_rf_write_d  = 1'b1;
          w_rf_wraddr_d = r_cnt + ADDR_W'(1);
          w_rf_wrdata_d = '0;
        end
      end

      StResp: begin
        if (i_rsp_ready) begin
          w_state_d     = StIdle;
          w_rsp_valid_d = 1'b0;
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_op         <= OpRead;
      r_dst        <= '0;
      r_cnt        <= '0;
      r_rf_write   <= 1'b0;
      r_rf_rdaddr1 <= '0;
      r_rf_rdaddr2 <= '0;
      r_rf_wraddr  <= '0;
      r_rf_wrdata  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data_a <= '0;
      r_rsp_data_b <= '0;
`ifdef RFC_READBACK_EN
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_d;
      r_op         <= w_op_d;
      r_dst        <= w_dst_d;
      r_cnt        <= w_cnt_d;
      r_rf_write   <= w_rf_write_d;
      r_rf_rdaddr1 <= w_rf_rdaddr1_d;
      r_rf_rdaddr2 <= w_rf_rdaddr2_d;
      r_rf_wraddr  <= w_rf_wraddr_d;
      r_rf_wrdata  <= w_rf_wrdata_d;
      r_rsp_valid  <= w_rsp_valid_d;
      r_rsp_data_a <= w_rsp_data_a_d;
      r_rsp_data_b <= w_rsp_data_b_d;
`ifdef RFC_READBACK_EN
      r_rsp_err    <= w_rsp_err_d;
`endif
    end
  end

  assign o_cmd_ready  = (r_state == StIdle);
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data_a = r_rsp_data_a;
  assign o_rsp_data_b = r_rsp_data_b;
  assign o_rf_write   = r_rf_write;
  assign o_rf_rdaddr1 = r_rf_rdaddr1;
  assign o_rf_rdaddr2 = r_rf_rdaddr2;
  assign o_rf_wraddr  = r_rf_wraddr;
  assign o_rf_wrdata  = r_rf_wrdata;
`ifdef RFC_READBACK_EN
  assign o_rsp_err    = r_rsp_err;
`else
  assign o_rsp_err    = 1'b0;
`endif

endmodule
